audio_reg_slave: RTL and testbench
==================================

// Module: audio_reg_slave
// PURPOSE
//  AXI-lite-style write slave that consumes the write transactions issued by master_dev.
//  Accepts address (AW) and data (W) on independent handshakes, in either order or in the same cycle.
//  Commits each write into a small audio-control register file and returns a write response (B).
//  The register contents are exported flat to the audio datapath.
// PARAMETERS
//  ADDR_W    4   width of AWADDR
//  DATA_W    7   width of WDATA and of each register
//  NUM_REGS  12  implemented registers, index 0..NUM_REGS-1 (NUM_REGS <= 2**ADDR_W)
// PORTS
//  clk        in   1                 rising-edge clock
//  ARESETn    in   1                 asynchronous active-low reset
//  AWADDR     in   ADDR_W            write address
//  AWVALID    in   1                 address valid
//  AWREADY    out  1                 address ready
//  WDATA      in   DATA_W            write data
//  WVALID     in   1                 data valid
//  WREADY     out  1                 data ready
//  BVALID     out  1                 response valid
//  BREADY     in   1                 response ready
//  BRESP      out  2                 2'b00 OKAY; 2'b10 SLVERR (address >= NUM_REGS)
//  regs_flat  out  NUM_REGS*DATA_W   register i occupies bits [i*DATA_W +: DATA_W]
//  wr_strobe  out  1                 one-cycle pulse when a register is written
//  wr_index   out  ADDR_W            index of the last committed write
// BEHAVIOUR
//  Reset (ARESETn=0, asynchronous)
//   - All outputs and all registers = 0; FSM = IDLE; capture flags cleared.
//   - First rising edge after deassertion: AWREADY=1, WREADY=1.
//  Handshakes
//   - A transfer occurs on a rising edge with VALID&READY high. All outputs are registered.
//  FSM states
//   - IDLE: collect AW and W.
//     * AW handshake latches AWADDR and sets aw_got; AWREADY drops to 0 the next cycle.
//     * W handshake latches WDATA and sets w_got; WREADY drops to 0 the next cycle.
//     * Both handshakes on the same edge are legal.
//     * When aw_got and w_got are both set (including same edge) -> COMMIT.
//       Both READYs are 0 from that edge onward.
//   - COMMIT (1 cycle): on its closing edge ->
//     * if addr < NUM_REGS: register[addr] <= data, BRESP=00, wr_strobe=1, wr_index=addr;
//     * else: no register change, BRESP=10, wr_strobe=0, wr_index unchanged.
//     * BVALID=1; -> RESP.
//   - RESP: BVALID, BRESP and wr_index held stable until BREADY=1.
//     * wr_strobe returns to 0 after one cycle.
//     * On the BVALID&BREADY edge: BVALID=0, BRESP=00, AWREADY=WREADY=1, flags cleared -> IDLE.
//  Latency
//   - Last of AW/W at edge N -> register updates and BVALID rises at edge N+1.
//   - With BREADY held high, READYs return at edge N+2; minimum 3 cycles per write.
//  Boundaries
//   - VALID inputs are ignored whenever the corresponding READY is 0; no transfer is lost or duplicated.
//   - Repeated writes to the same address: last write wins.
//   - Address NUM_REGS..2**ADDR_W-1: SLVERR response, register file untouched.
//   - Reset mid-transaction (any state) aborts it immediately.
//     * Partial captures are discarded; registers clear; no response is issued.
// TESTING
//  1. Reset, then AWVALID=WVALID=1 (AWADDR=3, WDATA=7'h55) together, BREADY=1
//     -> reg3=7'h55 and BVALID=1 one edge after the handshake; BRESP=00; wr_strobe 1 cycle, wr_index=3.
//  2. W first (WDATA=7'h12); AW (AWADDR=0) three cycles later
//     -> WREADY=0 while waiting; reg0=7'h12 one edge after the AW handshake.
//  3. AWADDR=4'hE, WDATA=7'h7F -> BRESP=2'b10; regs_flat unchanged; wr_strobe stays 0.
//  4. BREADY=0 for 5 cycles after BVALID -> BVALID/BRESP held; AWREADY=WREADY=0 throughout;
//     new AWVALID/WVALID ignored; READYs return the cycle after BREADY=1.
//  5. Back-to-back writes with VALIDs and BREADY tied 1 (master_dev bench style)
//     -> one write every 3 cycles, data in address order, no drops.
//  6. ARESETn pulsed low while in RESP after writing reg5=7'h2A
//     -> BVALID=0 immediately, reg5=0; READYs=1 on the first edge after release.

Source files
------------

// File: rtl/audio_reg_slave.sv
// audio_reg_slave: AXI-lite-style write slave committing writes into an audio-control register file.
// Ports:
//   clk, ARESETn                 rising-edge clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY       write address channel
//   WDATA/WVALID/WREADY          write data channel
//   BVALID/BREADY/BRESP          write response channel (00 OKAY, 10 SLVERR)
//   regs_flat                    register i at [i*DATA_W +: DATA_W]
//   wr_strobe, wr_index          one-cycle commit pulse and index of last committed write
module audio_reg_slave #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 7,
    parameter int NUM_REGS = 12
) (
    input  logic                       clk,
    input  logic                       ARESETn,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [1:0]                 BRESP,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_index
);
    typedef enum logic [1:0] {IDLE, COMMIT, RESP} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   aw_addr;
    logic [DATA_W-1:0]   w_data;
    logic                aw_got, w_got;
    logic                aw_n, w_n, in_range;
    // READYs are only ever high in IDLE, so these imply a handshake in IDLE
    assign aw_n     = aw_got | (AWVALID & AWREADY);
    assign w_n      = w_got | (WVALID & WREADY);
    assign in_range = int'(aw_addr) < NUM_REGS;
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            aw_addr   <= '0;
            w_data    <= '0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= 2'b00;
            regs_flat <= '0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (AWVALID && AWREADY) aw_addr <= AWADDR;
                    if (WVALID && WREADY) w_data <= WDATA;
                    aw_got  <= aw_n;
                    w_got   <= w_n;
                    // a channel stays ready until its beat has been captured
                    AWREADY <= !(aw_n && w_n) && !aw_n;
                    WREADY  <= !(aw_n && w_n) && !w_n;
                    state   <= (aw_n && w_n) ? COMMIT : IDLE;
                end
                COMMIT: begin
                    if (in_range) begin
                        regs_flat[int'(aw_addr)*DATA_W +: DATA_W] <= w_data;
                        wr_index <= aw_addr;
                    end
                    wr_strobe <= in_range;
                    BRESP     <= in_range ? 2'b00 : 2'b10;
                    BVALID    <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= 2'b00;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_reg_slave.sv
// tb_audio_reg_slave: randomized self-checking bench for audio_reg_slave against a register-array model.
module tb_audio_reg_slave;
    localparam int AW = 4;
    localparam int DW = 7;
    localparam int NR = 12;
    logic            clk = 1'b0;
    logic            ARESETn = 1'b0;
    logic [AW-1:0]   AWADDR = '0;
    logic            AWVALID = 1'b0;
    logic            AWREADY;
    logic [DW-1:0]   WDATA = '0;
    logic            WVALID = 1'b0;
    logic            WREADY;
    logic            BVALID;
    logic            BREADY = 1'b0;
    logic [1:0]      BRESP;
    logic [NR*DW-1:0] regs_flat;
    logic            wr_strobe;
    logic [AW-1:0]   wr_index;
    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] mregs [NR];
    logic [AW-1:0] midx = '0;
    audio_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_index(wr_index)
    );
    always #5 clk = ~clk;
    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    function automatic logic [NR*DW-1:0] mflat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mregs[i];
        return f;
    endfunction
    function automatic bit mwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (int'(a) >= NR) return 1'b0;
        mregs[a] = d;
        midx = a;
        return 1'b1;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // presents AW and W after independent delays; returns one cycle after the later handshake
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input int aw_dly, input int w_dly, output bit ok);
        int t = 0;
        bit ad = 0, wd = 0, af, wf;
        while (t < 40 && !(ad && wd)) begin
            AWADDR  = a;
            WDATA   = d;
            AWVALID = !ad && t >= aw_dly;
            WVALID  = !wd && t >= w_dly;
            af = AWVALID && AWREADY;
            wf = WVALID && WREADY;
            step();
            ad |= af;
            wd |= wf;
            t++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ok = ad && wd;
    endtask
    task automatic test_reset();
        ARESETn = 1'b0;
        step();
        step();
        n_chk++; if (AWREADY !== 1'b0 || WREADY !== 1'b0) $display("FAIL rst_ready got=%b%b exp=00", AWREADY, WREADY); else n_pass++;
        n_chk++; if (BVALID !== 1'b0 || BRESP !== 2'b00) $display("FAIL rst_b got=%b/%b exp=0/00", BVALID, BRESP); else n_pass++;
        n_chk++; if (regs_flat !== '0 || wr_strobe !== 1'b0 || wr_index !== '0) $display("FAIL rst_regs got=%h/%b/%h exp=0", regs_flat, wr_strobe, wr_index); else n_pass++;
        ARESETn = 1'b1;
        step();
        n_chk++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) $display("FAIL rst_release got=%b%b exp=11", AWREADY, WREADY); else n_pass++;
    endtask
    task automatic test_same_cycle();
        bit ok;
        BREADY = 1'b1;
        send(4'd3, 7'h55, 0, 0, ok);
        void'(mwrite(4'd3, 7'h55));
        n_chk++; if (!ok || BVALID !== 1'b0 || AWREADY !== 1'b0 || WREADY !== 1'b0) $display("FAIL t1_commit got ok=%b bv=%b rdy=%b%b exp 1/0/00", ok, BVALID, AWREADY, WREADY); else n_pass++;
        step();
        n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b00) $display("FAIL t1_resp got=%b/%b exp=1/00", BVALID, BRESP); else n_pass++;
        n_chk++; if (wr_strobe !== 1'b1 || wr_index !== 4'd3) $display("FAIL t1_strobe got=%b/%0d exp=1/3", wr_strobe, wr_index); else n_pass++;
        n_chk++; if (regs_flat !== mflat()) $display("FAIL t1_regs got=%h exp=%h", regs_flat, mflat()); else n_pass++;
        step();
        n_chk++; if (BVALID !== 1'b0 || wr_strobe !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) $display("FAIL t1_done got bv=%b st=%b rdy=%b%b exp 0/0/11", BVALID, wr_strobe, AWREADY, WREADY); else n_pass++;
    endtask
    task automatic test_w_first();
        BREADY = 1'b1;
        WDATA  = 7'h12;
        WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (WREADY !== 1'b0 || AWREADY !== 1'b1) $display("FAIL t2_wait%0d got rdy=%b%b exp aw=1 w=0", i, AWREADY, WREADY); else n_pass++;
            step();
        end
        AWADDR  = 4'd0;
        AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        void'(mwrite(4'd0, 7'h12));
        n_chk++; if (BVALID !== 1'b0 || WREADY !== 1'b0) $display("FAIL t2_commit got bv=%b w=%b exp 0/0", BVALID, WREADY); else n_pass++;
        step();
        n_chk++; if (BVALID !== 1'b1 || regs_flat !== mflat() || wr_index !== 4'd0) $display("FAIL t2_resp got bv=%b regs=%h idx=%0d exp 1/%h/0", BVALID, regs_flat, wr_index, mflat()); else n_pass++;
        step();
    endtask
    task automatic test_slverr();
        bit ok;
        BREADY = 1'b1;
        send(4'hE, 7'h7F, 0, 0, ok);
        void'(mwrite(4'hE, 7'h7F));
        step();
        n_chk++; if (!ok || BVALID !== 1'b1 || BRESP !== 2'b10) $display("FAIL t3_resp got ok=%b bv=%b br=%b exp 1/1/10", ok, BVALID, BRESP); else n_pass++;
        n_chk++; if (wr_strobe !== 1'b0 || wr_index !== midx || regs_flat !== mflat()) $display("FAIL t3_untouched got st=%b idx=%0d regs=%h exp 0/%0d/%h", wr_strobe, wr_index, regs_flat, midx, mflat()); else n_pass++;
        step();
        n_chk++; if (BVALID !== 1'b0 || BRESP !== 2'b00) $display("FAIL t3_clear got=%b/%b exp=0/00", BVALID, BRESP); else n_pass++;
    endtask
    task automatic test_bready_stall();
        bit ok;
        logic [DW-1:0] d = 7'($urandom);
        BREADY = 1'b0;
        send(4'd7, d, 0, 1, ok);
        void'(mwrite(4'd7, d));
        step();
        n_chk++; if (!ok || BVALID !== 1'b1 || wr_strobe !== 1'b1) $display("FAIL t4_resp got ok=%b bv=%b st=%b exp 1/1/1", ok, BVALID, wr_strobe); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            AWADDR  = 4'(i);
            WDATA   = 7'($urandom);
            AWVALID = 1'b1;
            WVALID  = 1'b1;
            step();
            n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0 || wr_strobe !== 1'b0) $display("FAIL t4_hold%0d got bv=%b br=%b rdy=%b%b st=%b exp 1/00/00/0", i, BVALID, BRESP, AWREADY, WREADY, wr_strobe); else n_pass++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        step();
        n_chk++; if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1 || regs_flat !== mflat()) $display("FAIL t4_release got bv=%b rdy=%b%b regs=%h exp 0/11/%h", BVALID, AWREADY, WREADY, regs_flat, mflat()); else n_pass++;
    endtask
    task automatic test_back_to_back();
        logic [DW-1:0] dat [NR];
        int k = 0, cyc = 0, prev = -1, strobes = 0;
        bit fire;
        for (int i = 0; i < NR; i++) dat[i] = 7'($urandom);
        BREADY = 1'b1;
        while (k < NR && cyc < 100) begin
            AWADDR  = 4'(k);
            WDATA   = dat[k];
            AWVALID = 1'b1;
            WVALID  = 1'b1;
            fire = AWREADY && WREADY;
            step();
            cyc++;
            strobes += int'(wr_strobe);
            if (fire) begin
                void'(mwrite(4'(k), dat[k]));
                if (prev >= 0) begin
                    n_chk++; if (cyc - prev !== 3) $display("FAIL t5_spacing%0d got=%0d exp=3", k, cyc - prev); else n_pass++;
                end
                prev = cyc;
                k++;
            end
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            strobes += int'(wr_strobe);
        end
        n_chk++; if (k !== NR || strobes !== NR) $display("FAIL t5_count got writes=%0d strobes=%0d exp %0d", k, strobes, NR); else n_pass++;
        n_chk++; if (regs_flat !== mflat() || wr_index !== 4'(NR-1)) $display("FAIL t5_regs got=%h idx=%0d exp=%h idx=%0d", regs_flat, wr_index, mflat(), NR-1); else n_pass++;
    endtask
    task automatic test_random();
        bit ok, good;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int hold, t;
        for (int n = 0; n < 25; n++) begin
            a = 4'($urandom);
            d = 7'($urandom);
            BREADY = 1'b0;
            send(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ok);
            good = mwrite(a, d);
            t = 0;
            while (BVALID !== 1'b1 && t < 5) begin
                step();
                t++;
            end
            n_chk++; if (!ok || t !== 1) $display("FAIL rnd%0d_latency got ok=%b edges=%0d exp 1/1", n, ok, t); else n_pass++;
            n_chk++; if (BRESP !== (good ? 2'b00 : 2'b10) || wr_strobe !== good || wr_index !== midx || regs_flat !== mflat()) $display("FAIL rnd%0d_commit a=%0d got br=%b st=%b idx=%0d regs=%h exp %b/%b/%0d/%h", n, a, BRESP, wr_strobe, wr_index, regs_flat, good ? 2'b00 : 2'b10, good, midx, mflat()); else n_pass++;
            hold = int'($urandom_range(0, 2));
            for (int i = 0; i < hold; i++) step();
            n_chk++; if (BVALID !== 1'b1 || AWREADY !== 1'b0) $display("FAIL rnd%0d_hold got bv=%b aw=%b exp 1/0", n, BVALID, AWREADY); else n_pass++;
            BREADY = 1'b1;
            step();
            n_chk++; if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) $display("FAIL rnd%0d_done got bv=%b rdy=%b%b exp 0/11", n, BVALID, AWREADY, WREADY); else n_pass++;
        end
        BREADY = 1'b0;
    endtask
    task automatic test_reset_mid();
        bit ok;
        BREADY = 1'b0;
        send(4'd5, 7'h2A, 0, 0, ok);
        void'(mwrite(4'd5, 7'h2A));
        step();
        n_chk++; if (!ok || BVALID !== 1'b1 || regs_flat[5*DW +: DW] !== 7'h2A) $display("FAIL t6_pre got ok=%b bv=%b reg5=%h exp 1/1/2a", ok, BVALID, regs_flat[5*DW +: DW]); else n_pass++;
        ARESETn = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        midx = '0;
        n_chk++; if (BVALID !== 1'b0 || regs_flat !== mflat() || AWREADY !== 1'b0 || wr_index !== '0) $display("FAIL t6_async got bv=%b regs=%h aw=%b idx=%0d exp 0/0/0/0", BVALID, regs_flat, AWREADY, wr_index); else n_pass++;
        step();
        ARESETn = 1'b1;
        step();
        n_chk++; if (AWREADY !== 1'b1 || WREADY !== 1'b1 || BVALID !== 1'b0) $display("FAIL t6_release got rdy=%b%b bv=%b exp 11/0", AWREADY, WREADY, BVALID); else n_pass++;
        AWADDR  = 4'd1;
        AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        ARESETn = 1'b0;
        step();
        ARESETn = 1'b1;
        step();
        WDATA  = 7'h33;
        WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        step();
        step();
        n_chk++; if (AWREADY !== 1'b1 || WREADY !== 1'b0 || BVALID !== 1'b0 || regs_flat !== mflat()) $display("FAIL t6_discard got rdy=%b%b bv=%b regs=%h exp 10/0/%h", AWREADY, WREADY, BVALID, regs_flat, mflat()); else n_pass++;
    endtask
    initial begin
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        test_reset();
        test_same_cycle();
        test_w_first();
        test_slverr();
        test_bready_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
